// File: rtl/delay_scan_seq.sv
// Delay scan sequencer: steps the echo delay through a list of points,
// holding each for a number of SYNC periods. Updates land on SYNC rising
// edges so the pulse generator never sees a delay change mid-period.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | passthrough of del_start, waiting for start
// ARM   | scan accepted, waiting for the first SYNC edge to open shot 0
// RUN   | each SYNC edge closes one shot; step delay at end of a point
module delay_scan_seq #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] del_start,
    input  logic [DW-1:0] del_step,
    input  logic [CW-1:0] n_points,
    input  logic [CW-1:0] shots,
    input  logic          sync_in,
    output logic [DW-1:0] del_out,
    output logic          busy,
    output logic [CW-1:0] point_idx,
    output logic          point_done,
    output logic          scan_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [DW-1:0] DMAX_C = {DW{1'b1}};

    state_t        state_q, state_d;
    logic          sync_q;
    logic [DW-1:0] del_cur_q, del_cur_d;
    logic [DW-1:0] del_out_q, del_out_d;
    logic [DW-1:0] step_q, step_d;
    logic [CW-1:0] pts_last_q, pts_last_d;
    logic [CW-1:0] shots_last_q, shots_last_d;
    logic [CW-1:0] shot_cnt_q, shot_cnt_d;
    logic [CW-1:0] point_idx_q, point_idx_d;
    logic          point_done_q, point_done_d;
    logic          scan_done_q, scan_done_d;

    logic                 sync_edge;
    logic signed [DW+1:0] sum_ext;
    logic [DW-1:0]        del_next;

    assign sync_edge = sync_in & ~sync_q;

    // Next delay point: signed add with two guard bits, clamped to [0, 2^DW-1]
    always_comb begin
        sum_ext = $signed({2'b00, del_cur_q}) + $signed({{2{step_q[DW-1]}}, step_q});
        if (sum_ext[DW+1]) begin
            del_next = '0;
        end else if (sum_ext[DW]) begin
            del_next = DMAX_C;
        end else begin
            del_next = sum_ext[DW-1:0];
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        del_cur_d    = del_cur_q;
        del_out_d    = del_out_q;
        step_d       = step_q;
        pts_last_d   = pts_last_q;
        shots_last_d = shots_last_q;
        shot_cnt_d   = shot_cnt_q;
        point_idx_d  = point_idx_q;
        point_done_d = 1'b0;
        scan_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                del_out_d   = del_start;
                point_idx_d = '0;
                shot_cnt_d  = '0;
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d      = ARM;
                    del_cur_d    = del_start;
                    step_d       = del_step;
                    pts_last_d   = (n_points == '0) ? '0 : n_points - ONE_C;
                    shots_last_d = (shots == '0) ? '0 : shots - ONE_C;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d   = IDLE;
                    del_out_d = del_start;
                end else if (sync_edge) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    del_out_d   = del_start;
                    point_idx_d = '0;
                    shot_cnt_d  = '0;
                end else if (sync_edge) begin
                    if (shot_cnt_q != shots_last_q) begin
                        shot_cnt_d = shot_cnt_q + ONE_C;
                    end else if (point_idx_q != pts_last_q) begin
                        point_done_d = 1'b1;
                        point_idx_d  = point_idx_q + ONE_C;
                        shot_cnt_d   = '0;
                        del_cur_d    = del_next;
                        del_out_d    = del_next;
                    end else begin
                        point_done_d = 1'b1;
                        scan_done_d  = 1'b1;
                        state_d      = IDLE;
                        del_out_d    = del_start;
                        point_idx_d  = '0;
                        shot_cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                del_out_d = del_start;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 1'b0;
            del_cur_q    <= '0;
            del_out_q    <= '0;
            step_q       <= '0;
            pts_last_q   <= '0;
            shots_last_q <= '0;
            shot_cnt_q   <= '0;
            point_idx_q  <= '0;
            point_done_q <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_in;
            del_cur_q    <= del_cur_d;
            del_out_q    <= del_out_d;
            step_q       <= step_d;
            pts_last_q   <= pts_last_d;
            shots_last_q <= shots_last_d;
            shot_cnt_q   <= shot_cnt_d;
            point_idx_q  <= point_idx_d;
            point_done_q <= point_done_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign del_out    = del_out_q;
    assign busy       = (state_q != IDLE);
    assign point_idx  = point_idx_q;
    assign point_done = point_done_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_delay_scan_seq.sv
// Directed bench for delay_scan_seq. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the registering rising edge.
module tb_delay_scan_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, sync_in;
    logic [15:0] del_start, del_step, n_points, shots;
    logic [15:0] del_out, point_idx;
    logic        busy, point_done, scan_done;

    int n_chk  = 0;
    int n_fail = 0;

    delay_scan_seq #(.DW(16), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .del_start  (del_start),
        .del_step   (del_step),
        .n_points   (n_points),
        .shots      (shots),
        .sync_in    (sync_in),
        .del_out    (del_out),
        .busy       (busy),
        .point_idx  (point_idx),
        .point_done (point_done),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One SYNC rising edge; returns outputs in the cycle after the edge and
    // the strobes one cycle later
    task automatic pulse(output logic [15:0] d, output logic [15:0] idx,
                         output logic pd, output logic sd, output logic pd2, output logic sd2);
        sync_in = 1'b1;
        @(negedge clk);
        d = del_out; idx = point_idx; pd = point_done; sd = scan_done;
        sync_in = 1'b0;
        @(negedge clk);
        pd2 = point_done; sd2 = scan_done;
    endtask

    task automatic do_start(input logic [15:0] ds, input logic [15:0] st,
                            input logic [15:0] np, input logic [15:0] sh);
        del_start = ds; del_step = st; n_points = np; shots = sh;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [15:0] d, idx;
    logic        pd, sd, pd2, sd2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_d[1:6];
        logic [15:0] exp_i[1:6];
        exp_d = '{16'd100, 16'd100, 16'd110, 16'd110, 16'd120, 16'd120};
        exp_i = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sync_in = 1'b0;
        del_start = 16'd0; del_step = 16'd0; n_points = 16'd0; shots = 16'd0;
        #1;
        chk("rst_del_out", del_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_point_idx", point_idx, 0);
        chk("rst_strobes", {point_done, scan_done}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        del_start = 16'd321;
        @(negedge clk);
        chk("idle_passthrough", del_out, 321);

        // Basic scan
        do_start(16'd100, 16'd10, 16'd3, 16'd2);
        chk("start_busy", busy, 1);
        chk("start_del_out", del_out, 100);
        for (int k = 1; k <= 7; k++) begin
            pulse(d, idx, pd, sd, pd2, sd2);
            if (k <= 6) begin
                chk($sformatf("basic_del_e%0d", k), d, exp_d[k]);
                chk($sformatf("basic_idx_e%0d", k), idx, exp_i[k]);
            end
            chk($sformatf("basic_pd_e%0d", k), pd, (k == 3 || k == 5 || k == 7));
            chk($sformatf("basic_sd_e%0d", k), sd, (k == 7));
            chk($sformatf("basic_strobe_len_e%0d", k), {pd2, sd2}, 0);
        end
        @(negedge clk);
        chk("basic_end_busy", busy, 0);
        chk("basic_end_del_out", del_out, 100);

        // Saturation high
        do_start(16'hFFF0, 16'h0010, 16'd3, 16'd1);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_hi_p0", d, 16'hFFF0);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_hi_p1", d, 16'hFFFF);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_hi_p2", d, 16'hFFFF);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_hi_done", sd, 1);

        // Saturation low
        do_start(16'd5, 16'hFFFC, 16'd3, 16'd1);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_lo_p0", d, 5);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_lo_p1", d, 1);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_lo_p2", d, 0);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("sat_lo_done", sd, 1);

        // Zero counts: one point of one shot
        do_start(16'd40, 16'd1, 16'd0, 16'd0);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("zero_e1_sd", {pd, sd}, 0);
        pulse(d, idx, pd, sd, pd2, sd2);
        chk("zero_e2_sd", {pd, sd}, 2'b11);
        chk("zero_e2_busy", busy, 0);

        // Abort after 3 edges
        do_start(16'd100, 16'd10, 16'd3, 16'd2);
        for (int k = 1; k <= 3; k++) pulse(d, idx, pd, sd, pd2, sd2);
        chk("abort_pre_del", del_out, 110);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_del_out", del_out, 100);
        for (int k = 1; k <= 6; k++) begin
            pulse(d, idx, pd, sd, pd2, sd2);
            chk($sformatf("abort_no_strobe_%0d", k), {pd, sd}, 0);
        end

        // Abort and start together in IDLE
        del_start = 16'd100;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", busy, 0);

        // Start while busy, held-high SYNC, n_points changed mid-scan
        do_start(16'd100, 16'd10, 16'd3, 16'd2);
        pulse(d, idx, pd, sd, pd2, sd2);
        pulse(d, idx, pd, sd, pd2, sd2);
        n_points = 16'd0;
        shots    = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", busy, 1);
        chk("busy_start_idx", point_idx, 0);
        chk("busy_start_del", del_out, 100);
        sync_in = 1'b1;
        @(negedge clk);
        chk("held_first_pd", point_done, 1);
        chk("held_first_idx", point_idx, 1);
        for (int k = 0; k < 49; k++) @(negedge clk);
        chk("held_idx", point_idx, 1);
        chk("held_pd_gone", point_done, 0);
        sync_in = 1'b0;
        @(negedge clk);
        for (int k = 4; k <= 7; k++) begin
            pulse(d, idx, pd, sd, pd2, sd2);
            chk($sformatf("len_pd_e%0d", k), pd, (k == 5 || k == 7));
            chk($sformatf("len_sd_e%0d", k), sd, (k == 7));
        end
        chk("len_busy_end", busy, 0);

        // start in the same cycle as scan_done is ignored
        do_start(16'd200, 16'd1, 16'd1, 16'd1);
        pulse(d, idx, pd, sd, pd2, sd2);
        sync_in = 1'b1; start = 1'b1;
        @(negedge clk);
        sync_in = 1'b0; start = 1'b0;
        chk("done_start_sd", scan_done, 1);
        @(negedge clk);
        chk("done_start_busy", busy, 0);

        // Reset mid-RUN
        do_start(16'd100, 16'd10, 16'd3, 16'd2);
        for (int k = 1; k <= 3; k++) pulse(d, idx, pd, sd, pd2, sd2);
        chk("rst_mid_pre_idx", point_idx, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_del", del_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_idx", point_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        del_start = 16'd77;
        @(negedge clk);
        chk("rst_release_pass", del_out, 77);
        chk("rst_release_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
